// File: rtl/pe_pkg.sv
// pe_pkg: shared constants, pipeline tag and response-entry types for the PE arbiter.
package pe_pkg;

    localparam int PE_N_REQ_DEF      = 4;
    localparam int PE_C_DEF          = 8;
    localparam int PE_W_X_DEF        = 8;
    localparam int PE_W_K_DEF        = 8;
    localparam int PE_LAT_DEF        = 1;
    localparam int PE_FIFO_DEPTH_DEF = 4;

    // Fields sized for the largest legal configuration (16 requesters, 32-bit results).
    localparam int PE_ID_W  = 4;
    localparam int PE_Y_W   = 32;
    localparam int PE_CNT_W = 32;

    typedef struct packed {
        logic               vld;
        logic [PE_ID_W-1:0] id;
    } pe_tag_t;

    typedef struct packed {
        logic [PE_ID_W-1:0] id;
        logic [PE_Y_W-1:0]  y;
    } pe_rsp_t;

    function automatic logic [PE_CNT_W-1:0] sat_inc(input logic [PE_CNT_W-1:0] v);
        return (v == {PE_CNT_W{1'b1}}) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pe_rsp_fifo.sv
// pe_rsp_fifo: synchronous response FIFO with full/empty/count; head is shown combinationally.
module pe_rsp_fifo
    import pe_pkg::*;
#(
    parameter  int DEPTH = PE_FIFO_DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  pe_rsp_t       din,
    input  logic          pop,
    output pe_rsp_t       dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    pe_rsp_t       r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_push_ok;
    logic          w_pop_ok;

    // A pop frees the slot being written, so a full FIFO may accept a same-cycle push.
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '{id: {PE_ID_W{1'b0}}, y: {PE_Y_W{1'b0}}};
            end
            r_wr  <= {AW{1'b0}};
            r_rd  <= {AW{1'b0}};
            r_cnt <= {(AW+1){1'b0}};
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr] <= din;
                r_wr        <= r_wr + AW'(1'b1);
            end
            if (w_pop_ok) begin
                r_rd <= r_rd + AW'(1'b1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1'b1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1'b1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign dout  = r_mem[r_rd];
    assign count = r_cnt;
    assign full  = (r_cnt == (AW+1)'(DEPTH));
    assign empty = (r_cnt == {(AW+1){1'b0}});

endmodule

// File: rtl/pe_arb.sv
// pe_arb: round-robin sharing of one dot-product PE, credit-limited so every result has a
// reserved response slot. Define PE_ARB_STATS_EN to add grant/stall statistics ports.
module pe_arb
    import pe_pkg::*;
#(
    parameter int N_REQ      = PE_N_REQ_DEF,
    parameter int C          = PE_C_DEF,
    parameter int W_X        = PE_W_X_DEF,
    parameter int W_K        = PE_W_K_DEF,
    parameter int LAT        = PE_LAT_DEF,
    parameter int FIFO_DEPTH = PE_FIFO_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*C*W_K-1:0]   req_k,
    input  logic [N_REQ*C*W_X-1:0]   req_x,
    output logic                     pe_en,
    output logic [C*W_K-1:0]         pe_k,
    output logic [C*W_X-1:0]         pe_x,
    input  logic [W_X-1:0]           pe_y,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [W_X-1:0]           rsp_y
`ifdef PE_ARB_STATS_EN
    ,
    output logic [N_REQ*32-1:0]      stat_grants,
    output logic [31:0]              stat_stall
`endif
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int KW    = C * W_K;
    localparam int XW    = C * W_X;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [ID_W-1:0]  r_ptr;
    logic [KW-1:0]    r_pe_k;
    logic [XW-1:0]    r_pe_x;
    pe_tag_t          r_tag [0:LAT];
    logic             w_win_found;
    logic [ID_W-1:0]  w_win_id;
    logic [ID_W-1:0]  w_cand;
    logic [15:0]      w_in_flight;
    logic [CNT_W-1:0] w_fifo_cnt;
    logic             w_credit;
    logic             w_grant;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_unused;
    pe_rsp_t          w_push_d;
    pe_rsp_t          w_head;

    // Round-robin search: first valid requester at or above the pointer, wrapping.
    always_comb begin
        w_win_found = 1'b0;
        w_win_id    = {ID_W{1'b0}};
        w_cand      = {ID_W{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = ID_W'((int'(r_ptr) + k) % N_REQ);
            if (req_valid[w_cand] && !w_win_found) begin
                w_win_found = 1'b1;
                w_win_id    = w_cand;
            end else begin
                w_win_found = w_win_found;
            end
        end
    end

    // Tags still in the PE pipeline; together with the FIFO they must never exceed its depth.
    always_comb begin
        w_in_flight = 16'd0;
        for (int k = 0; k <= LAT; k++) begin
            w_in_flight = w_in_flight + 16'(r_tag[k].vld);
        end
    end

    assign w_credit = (w_in_flight + 16'(w_fifo_cnt)) < 16'(FIFO_DEPTH);
    assign w_grant  = w_win_found && w_credit && rstn;

    // One-hot accept for the winner only.
    always_comb begin
        req_ready = {N_REQ{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant && (w_win_id == ID_W'(i))) begin
                req_ready[i] = 1'b1;
            end else begin
                req_ready[i] = 1'b0;
            end
        end
    end

    // Pointer advance and operand capture on a grant.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr  <= {ID_W{1'b0}};
            r_pe_k <= {KW{1'b0}};
            r_pe_x <= {XW{1'b0}};
        end else if (w_grant) begin
            r_ptr  <= (w_win_id == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}} : w_win_id + ID_W'(1'b1);
            r_pe_k <= req_k[int'(w_win_id)*KW +: KW];
            r_pe_x <= req_x[int'(w_win_id)*XW +: XW];
        end
    end

    // Tag pipeline: stage 0 rides with pe_en, stage LAT lines up with a valid pe_y.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k <= LAT; k++) begin
                r_tag[k] <= '{vld: 1'b0, id: {PE_ID_W{1'b0}}};
            end
        end else begin
            r_tag[0] <= '{vld: w_grant, id: PE_ID_W'(w_win_id)};
            for (int k = 1; k <= LAT; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    assign w_push_d = '{id: r_tag[LAT].id, y: PE_Y_W'(pe_y)};
    assign w_pop    = rsp_valid && rsp_ready;

    pe_rsp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (r_tag[LAT].vld),
        .din   (w_push_d),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_fifo_cnt)
    );

    assign pe_en     = r_tag[0].vld;
    assign pe_k      = r_pe_k;
    assign pe_x      = r_pe_x;
    assign rsp_valid = !w_empty;
    assign rsp_id    = w_head.id[ID_W-1:0];
    assign rsp_y     = w_head.y[W_X-1:0];
    assign w_unused  = ^{w_head, w_full};

`ifdef PE_ARB_STATS_EN
    logic [31:0] r_stat_grants [N_REQ];
    logic [31:0] r_stat_stall;

    // Saturating per-requester grant counters and stall-cycle counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_stat_grants[i] <= 32'd0;
            end
            r_stat_stall <= 32'd0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_grant && (w_win_id == ID_W'(i))) begin
                    r_stat_grants[i] <= sat_inc(r_stat_grants[i]);
                end
            end
            if ((|req_valid) && !w_grant) begin
                r_stat_stall <= sat_inc(r_stat_stall);
            end
        end
    end

    // Flatten counters onto the packed port.
    always_comb begin
        stat_grants = {(N_REQ*32){1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            stat_grants[i*32 +: 32] = r_stat_grants[i];
        end
    end

    assign stat_stall = r_stat_stall;
`endif

endmodule

// File: doc/pe_arb.md
PE_ARB -- requirements
Module: pe_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing one dot-product PE (2..16).
REQ-002 SHALL have parameter C, default 8: vector lanes per operation.
REQ-003 SHALL have parameter W_X, default 8: activation element width and result width.
REQ-004 SHALL have parameter W_K, default 8: kernel element width.
REQ-005 SHALL have parameter LAT, default 1: PE latency in cycles from pe_en edge to valid pe_y (1..8).
REQ-006 SHALL have parameter FIFO_DEPTH, default 4: response buffer entries (power of 2, >= 2).
REQ-007 SHALL have a single clock and an asynchronous, active-low reset, with ports as below.
- clk  in  1  sole clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester operation request.
- req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle.
- req_k  in  N_REQ*C*W_K  packed signed kernel vectors, requester-major.
- req_x  in  N_REQ*C*W_X  packed signed activation vectors, requester-major.
- pe_en  out  1  PE enable, one cycle per issued operation.
- pe_k  out  C*W_K  registered kernel operand to PE.
- pe_x  out  C*W_X  registered activation operand to PE.
- pe_y  in  W_X  PE result (truncated dot product).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer accept.
- rsp_id  out  clog2(N_REQ)  originating requester index.
- rsp_y  out  W_X  result.

Function
REQ-008 SHALL grant at most one requester per cycle, round-robin from pointer ptr: lowest index at or above ptr with req_valid, wrapping to 0.
REQ-009 SHALL assert req_ready[i] combinationally only for the winner i, and only when credit is available.
REQ-010 SHALL define credit available as (in_flight + fifo_count) < FIFO_DEPTH, where in_flight = pipeline tags not yet captured.
REQ-011 SHALL, on req_valid[i] && req_ready[i] at edge t, load pe_k/pe_x from requester i and drive pe_en high during cycle t+1 only.
REQ-012 SHALL set ptr to (i+1) mod N_REQ after each grant; ptr SHALL hold when no grant occurs.
REQ-013 SHALL carry {valid, id} through a LAT-stage tag shift register aligned with pe_en.
REQ-014 SHALL push {id, pe_y} into the response FIFO when the tag emerges, i.e. LAT cycles after pe_en.
REQ-015 SHALL never drop a result; REQ-010 guarantees FIFO space at every push.
REQ-016 SHALL treat rsp_valid && rsp_ready as a pop; rsp_valid, rsp_id and rsp_y SHALL show the FIFO head and hold stable while rsp_valid && !rsp_ready.
REQ-017 SHALL handle a simultaneous push and pop when the FIFO is full or empty without loss; an empty-FIFO push SHALL appear on rsp_valid the next cycle.
REQ-018 SHALL sustain a throughput of one grant per cycle while rsp_ready stays high.
REQ-019 SHALL preserve response order equal to grant order.
REQ-020 SHALL ignore unselected requesters' operands entirely.

Reset
REQ-021 SHALL, on rstn low, asynchronously clear: ptr=0, tag valids=0, FIFO empty, pe_en=0, pe_k=0, pe_x=0, rsp_valid=0, and all stats counters.
REQ-022 SHALL drive req_ready all-zero during reset.
REQ-023 SHALL discard any in-flight operations on reset mid-operation; the first post-reset grant SHALL occur no earlier than the first edge after rstn rises.

Configuration
REQ-024 SHALL, with PE_ARB_STATS_EN defined, add output stat_grants (N_REQ*32): per-requester saturating grant counters, plus output stat_stall (32): counter of cycles with any req_valid but no grant.
REQ-025 SHALL, without PE_ARB_STATS_EN, omit those ports and counters; all other behaviour SHALL be identical.

Structure
REQ-026 SHALL place in shared package pe_pkg: the tag struct typedef {logic vld; id}, the response entry typedef {id, y}, and a default-width constant set.
REQ-027 SHALL implement the response buffer as sub-module pe_rsp_fifo (sync FIFO with full/empty/count).

Verification
REQ-028 Only req 2 valid, k all 1, x all 3, LAT=1 -> pe_en at t+1; rsp_id=2, rsp_y=24 at t+3.
REQ-029 All 4 valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; responses in the same order.
REQ-030 rsp_ready=0, all valid -> exactly 4 grants, then req_ready=0; one pop -> exactly one new grant.
REQ-031 FIFO full; same-cycle pop and push -> count stays 4; no loss; order preserved.
REQ-032 rstn pulsed low with 2 in flight -> rsp_valid=0 and pe_en=0 immediately; no stale response after release.
REQ-033 PE_ARB_STATS_EN, 10 grants to req 1 and 3 stall cycles -> stat_grants[1]=10, stat_stall=3.
